// File: rtl/nivel_pkg.sv
// nivel_pkg: FSM state encoding, Nivel codes and level-decoding helpers shared by condicionador_nivel.
package nivel_pkg;
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENCHENDO = 2'd1,
    CHEIO    = 2'd2,
    ERRO     = 2'd3
  } estado_t;
  localparam logic [1:0] NIVEL_VAZIO = 2'd0;
  localparam logic [1:0] NIVEL_BAIXO = 2'd1;
  localparam logic [1:0] NIVEL_MEDIO = 2'd2;
  localparam logic [1:0] NIVEL_CHEIO = 2'd3;
  // Probes wet from the bottom up; any gap in the stack is physically impossible.
  function automatic logic consistente(input logic [2:0] hml);
    return hml == 3'b000 || hml == 3'b001 || hml == 3'b011 || hml == 3'b111;
  endfunction
  function automatic logic [1:0] nivel_de(input logic [2:0] hml);
    return hml[2] ? NIVEL_CHEIO : hml[1] ? NIVEL_MEDIO : hml[0] ? NIVEL_BAIXO : NIVEL_VAZIO;
  endfunction
endpackage

// File: rtl/filtro_sonda.sv
// filtro_sonda: 2-flop synchronizer plus debouncer; level flips on the DEB_CICLOS-th consecutive differing sample.
module filtro_sonda #(
  parameter int DEB_CICLOS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEB_CICLOS);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CICLOS - 1);
  logic s1_q, s2_q, level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d   = (s2_q == level_q || cnt_q == CMAX) ? '0 : cnt_q + 1'b1;
    level_d = (s2_q != level_q && cnt_q == CMAX) ? ~level_q : level_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/condicionador_nivel.sv
// condicionador_nivel: debounced 3-probe tank level conditioner with fill-valve FSM.
// Define FILL_TIMEOUT_EN to add a watchdog that faults a fill lasting TIMEOUT_ENCHER cycles.
module condicionador_nivel #(
  parameter int DEB_CICLOS     = 8,
  parameter int ERRO_CICLOS    = 16,
  parameter int TIMEOUT_ENCHER = 1024
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Sonda_H,
  input  logic       Sonda_M,
  input  logic       Sonda_L,
  input  logic       Limpa_Erro,
  output logic       H,
  output logic       M,
  output logic       L,
  output logic       Ve,
  output logic       E,
  output logic [1:0] Nivel
);
  import nivel_pkg::*;
  // FSM holds until the debounce pipeline has had time to see real probe samples.
  localparam int AQ_LIM = DEB_CICLOS + 1;
  localparam int AW = $clog2(AQ_LIM + 1);
  localparam int IW = $clog2(ERRO_CICLOS + 1);
  if (DEB_CICLOS < 2 || ERRO_CICLOS < 1 || TIMEOUT_ENCHER < 2) begin : g_param_err
    $error("condicionador_nivel: parameter out of range");
  end
  logic [2:0] hml;
  filtro_sonda #(.DEB_CICLOS(DEB_CICLOS)) u_h (.clk(Clock), .rst(Reset), .raw(Sonda_H), .level(hml[2]));
  filtro_sonda #(.DEB_CICLOS(DEB_CICLOS)) u_m (.clk(Clock), .rst(Reset), .raw(Sonda_M), .level(hml[1]));
  filtro_sonda #(.DEB_CICLOS(DEB_CICLOS)) u_l (.clk(Clock), .rst(Reset), .raw(Sonda_L), .level(hml[0]));
  estado_t state_q, state_d;
  logic [AW-1:0] aq_q, aq_d;
  logic [IW-1:0] inc_q, inc_d;
  logic [1:0] nivel_q, nivel_d;
  logic ve_q, ve_d, e_q, e_d;
  logic cons, pronto, falha, estouro;
`ifdef FILL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_ENCHER);
  logic [TW-1:0] tmr_q, tmr_d;
  always_comb begin
    tmr_d   = (state_q == ENCHENDO && state_d == ENCHENDO) ? tmr_q + 1'b1 : '0;
    estouro = state_q == ENCHENDO && tmr_q == TW'(TIMEOUT_ENCHER - 1) && !hml[2];
  end
  always_ff @(posedge Clock) tmr_q <= Reset ? '0 : tmr_d;
`else
  assign estouro = 1'b0;
`endif
  always_comb begin
    cons    = consistente(hml);
    pronto  = aq_q == AW'(AQ_LIM);
    falha   = inc_q == IW'(ERRO_CICLOS) || estouro;
    aq_d    = pronto ? aq_q : aq_q + 1'b1;
    inc_d   = cons ? '0 : (inc_q == IW'(ERRO_CICLOS) ? inc_q : inc_q + 1'b1);
    nivel_d = cons ? nivel_de(hml) : nivel_q;
    ve_d    = state_q == ENCHENDO;
    e_d     = state_q == ERRO;
    state_d = !pronto                             ? state_q :
              state_q == ERRO                     ? ((Limpa_Erro && cons) ? OCIOSO : ERRO) :
              falha                               ? ERRO :
              (state_q == OCIOSO && hml[2])       ? CHEIO :
              (state_q == OCIOSO && !hml[1])      ? ENCHENDO :
              (state_q == ENCHENDO && hml[2])     ? CHEIO :
              (state_q == CHEIO && !hml[1])       ? ENCHENDO :
                                                    state_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= OCIOSO;
      aq_q    <= '0;
      inc_q   <= '0;
      nivel_q <= NIVEL_VAZIO;
      ve_q    <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      aq_q    <= aq_d;
      inc_q   <= inc_d;
      nivel_q <= nivel_d;
      ve_q    <= ve_d;
      e_q     <= e_d;
    end
  end
  assign {H, M, L} = hml;
  assign Ve        = ve_q;
  assign E         = e_q;
  assign Nivel     = nivel_q;
endmodule

// File: tb/tb_condicionador_nivel.sv
// tb_condicionador_nivel: directed scenarios plus randomized run against a sliding-window behavioural model.
module tb_condicionador_nivel;
  localparam int DEB = 8;
  localparam int ERR = 16;
  localparam int TO  = 64;
`ifdef FILL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic Clock = 1'b0, Reset = 1'b1, Sonda_H = 1'b0, Sonda_M = 1'b0, Sonda_L = 1'b0, Limpa_Erro = 1'b0;
  logic H, M, L, Ve, E;
  logic [1:0] Nivel;
  int n_tests = 0, n_fail = 0;

  condicionador_nivel #(.DEB_CICLOS(DEB), .ERRO_CICLOS(ERR), .TIMEOUT_ENCHER(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Sonda_H(Sonda_H), .Sonda_M(Sonda_M), .Sonda_L(Sonda_L),
    .Limpa_Erro(Limpa_Erro), .H(H), .M(M), .L(L), .Ve(Ve), .E(E), .Nivel(Nivel)
  );

  always #5 Clock = ~Clock;

  // Model: a level flips once the last DEB synchronized samples (raw delayed two edges) all disagree with it.
  // States: 0 idle, 1 filling, 2 full, 3 error. Nivel is the count of wet probes.
  bit [2:0] hist[$];
  bit [2:0] lvl;
  bit mve, me, cons, fault, ad;
  int mst, nst, mniv, run, warm, tmr;
  always @(posedge Clock) begin
    if (Reset) begin
      lvl = 3'b000; mst = 0; mniv = 0; run = 0; warm = 0; tmr = 0; mve = 0; me = 0;
      hist.delete();
      repeat (DEB + 1) hist.push_back(3'b000);
    end else begin
      cons  = lvl inside {3'b000, 3'b001, 3'b011, 3'b111};
      fault = run >= ERR || (TO_EN && mst == 1 && tmr >= TO - 1 && !lvl[2]);
      nst = mst;
      if (warm >= DEB + 1) begin
        if (mst == 3) nst = (Limpa_Erro && cons) ? 0 : 3;
        else if (fault) nst = 3;
        else if (mst == 0) nst = lvl[2] ? 2 : (!lvl[1] ? 1 : 0);
        else if (mst == 1) nst = lvl[2] ? 2 : 1;
        else nst = !lvl[1] ? 1 : 2;
      end
      mve = mst == 1;
      me  = mst == 3;
      if (cons) mniv = $countones(lvl);
      tmr  = (mst == 1 && nst == 1) ? tmr + 1 : 0;
      run  = cons ? 0 : (run < ERR ? run + 1 : run);
      mst  = nst;
      warm = warm < DEB + 1 ? warm + 1 : warm;
      for (int b = 0; b < 3; b++) begin
        ad = 1'b1;
        for (int k = 0; k < DEB; k++) if (hist[k][b] == lvl[b]) ad = 1'b0;
        if (ad) lvl[b] = ~lvl[b];
      end
      void'(hist.pop_front());
      hist.push_back({Sonda_H, Sonda_M, Sonda_L});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic set_raw(input bit [2:0] r);
    {Sonda_H, Sonda_M, Sonda_L} = r;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Limpa_Erro = 1'b0; set_raw(3'b000);
    tick(2);
    n_tests++;
    if ({H, M, L, Ve, E, Nivel} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs got %b want 0000000", {H, M, L, Ve, E, Nivel}); end
    Reset = 1'b0;
    tick(DEB + 2);
    n_tests++;
    if (Ve !== 1'b0) begin n_fail++; $display("FAIL startup_ve_early got %b want 0", Ve); end
    tick(1);
    n_tests++;
    if (Ve !== 1'b1) begin n_fail++; $display("FAIL startup_ve got %b want 1", Ve); end
    n_tests++;
    if (Nivel !== 2'd0 || E !== 1'b0) begin n_fail++; $display("FAIL startup_nivel_e got %0d/%b want 0/0", Nivel, E); end
  endtask

  task automatic test_fill;
    set_raw(3'b001);
    tick(DEB + 1);
    n_tests++;
    if (L !== 1'b0) begin n_fail++; $display("FAIL latency_early got L=%b want 0", L); end
    tick(1);
    n_tests++;
    if (L !== 1'b1) begin n_fail++; $display("FAIL latency_exact got L=%b want 1", L); end
    tick(10);
    n_tests++;
    if (Nivel !== 2'd1 || Ve !== 1'b1) begin n_fail++; $display("FAIL fill_low got %0d/%b want 1/1", Nivel, Ve); end
    set_raw(3'b011);
    tick(20);
    n_tests++;
    if (Nivel !== 2'd2 || Ve !== 1'b1 || M !== 1'b1) begin n_fail++; $display("FAIL fill_mid got %0d/%b/%b want 2/1/1", Nivel, Ve, M); end
    set_raw(3'b111);
    tick(DEB + 3);
    n_tests++;
    if (Ve !== 1'b1) begin n_fail++; $display("FAIL ve_before_drop got %b want 1", Ve); end
    tick(1);
    n_tests++;
    if (Ve !== 1'b0) begin n_fail++; $display("FAIL ve_drop got %b want 0", Ve); end
    tick(8);
    n_tests++;
    if (Nivel !== 2'd3 || H !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0d/%b want 3/1", Nivel, H); end
    set_raw(3'b011);
    tick(20);
    n_tests++;
    if (Ve !== 1'b0 || Nivel !== 2'd2) begin n_fail++; $display("FAIL hysteresis got %b/%0d want 0/2", Ve, Nivel); end
    set_raw(3'b001);
    tick(20);
    n_tests++;
    if (Ve !== 1'b1 || Nivel !== 2'd1) begin n_fail++; $display("FAIL refill got %b/%0d want 1/1", Ve, Nivel); end
  endtask

  task automatic test_glitch;
    Sonda_M = 1'b1;
    tick(DEB - 1);
    Sonda_M = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_tests++;
      if (M !== 1'b0) begin n_fail++; $display("FAIL glitch7 cycle %0d got M=%b want 0", i, M); end
    end
    Sonda_M = 1'b1;
    tick(DEB);
    Sonda_M = 1'b0;
    tick(1);
    n_tests++;
    if (M !== 1'b0) begin n_fail++; $display("FAIL pulse8_early got M=%b want 0", M); end
    tick(1);
    n_tests++;
    if (M !== 1'b1) begin n_fail++; $display("FAIL pulse8_accept got M=%b want 1", M); end
    tick(20);
    n_tests++;
    if (M !== 1'b0) begin n_fail++; $display("FAIL pulse8_return got M=%b want 0", M); end
  endtask

  task automatic test_erro;
    set_raw(3'b101);
    tick(DEB + 2 + ERR + 1);
    n_tests++;
    if (E !== 1'b0) begin n_fail++; $display("FAIL erro_early got E=%b want 0", E); end
    tick(1);
    n_tests++;
    if (E !== 1'b1 || Ve !== 1'b0) begin n_fail++; $display("FAIL erro_set got E=%b Ve=%b want 1/0", E, Ve); end
    n_tests++;
    if (Nivel !== 2'd1) begin n_fail++; $display("FAIL nivel_hold got %0d want 1", Nivel); end
    Limpa_Erro = 1'b1; tick(1); Limpa_Erro = 1'b0;
    tick(3);
    n_tests++;
    if (E !== 1'b1) begin n_fail++; $display("FAIL clear_ignored got E=%b want 1", E); end
    set_raw(3'b111);
    tick(20);
    n_tests++;
    if (E !== 1'b1 || Nivel !== 2'd3) begin n_fail++; $display("FAIL erro_sticky got E=%b Nivel=%0d want 1/3", E, Nivel); end
    Limpa_Erro = 1'b1; tick(1); Limpa_Erro = 1'b0;
    tick(1);
    n_tests++;
    if (E !== 1'b0 || Ve !== 1'b0) begin n_fail++; $display("FAIL clear_ok got E=%b Ve=%b want 0/0", E, Ve); end
    tick(3);
    n_tests++;
    if (E !== 1'b0 || Ve !== 1'b0) begin n_fail++; $display("FAIL cheio_after_clear got E=%b Ve=%b want 0/0", E, Ve); end
  endtask

  task automatic test_timeout;
    set_raw(3'b000);
    tick(DEB + 3);
    n_tests++;
    if (Ve !== 1'b0) begin n_fail++; $display("FAIL to_ve_early got %b want 0", Ve); end
    tick(1);
    n_tests++;
    if (Ve !== 1'b1) begin n_fail++; $display("FAIL to_ve_on got %b want 1", Ve); end
    if (TO_EN) begin
      tick(TO - 2);
      n_tests++;
      if (E !== 1'b0 || Ve !== 1'b1) begin n_fail++; $display("FAIL to_early got E=%b Ve=%b want 0/1", E, Ve); end
      tick(1);
      n_tests++;
      if (E !== 1'b1 || Ve !== 1'b0) begin n_fail++; $display("FAIL to_fire got E=%b Ve=%b want 1/0", E, Ve); end
    end else begin
      tick(200);
      n_tests++;
      if (E !== 1'b0 || Ve !== 1'b1) begin n_fail++; $display("FAIL no_timeout got E=%b Ve=%b want 0/1", E, Ve); end
    end
  endtask

  task automatic test_reset_mid;
    Reset = 1'b1; set_raw(3'b001);
    tick(1);
    Reset = 1'b0;
    tick(15);
    n_tests++;
    if (Ve !== 1'b1) begin n_fail++; $display("FAIL mid_filling got Ve=%b want 1", Ve); end
    Reset = 1'b1;
    tick(1);
    n_tests++;
    if ({H, M, L, Ve, E, Nivel} !== 7'b0) begin n_fail++; $display("FAIL mid_reset got %b want 0000000", {H, M, L, Ve, E, Nivel}); end
    Reset = 1'b0;
    tick(DEB + 1);
    n_tests++;
    if (L !== 1'b0) begin n_fail++; $display("FAIL mid_l_early got %b want 0", L); end
    tick(1);
    n_tests++;
    if (L !== 1'b1 || Ve !== 1'b0) begin n_fail++; $display("FAIL mid_l_back got L=%b Ve=%b want 1/0", L, Ve); end
    tick(1);
    n_tests++;
    if (Ve !== 1'b1) begin n_fail++; $display("FAIL mid_refill got Ve=%b want 1", Ve); end
  endtask

  task automatic test_random;
    bit [2:0] r = 3'b000;
    int rate = 16;
    Reset = 1'b1; set_raw(r); Limpa_Erro = 1'b0;
    tick(1);
    Reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rate = int'($urandom_range(4, 60));
      for (int b = 0; b < 3; b++) if ($urandom_range(0, rate - 1) == 0) r[b] = ~r[b];
      set_raw(r);
      Limpa_Erro = $urandom_range(0, 19) == 0;
      Reset = $urandom_range(0, 799) == 0;
      tick(1);
      n_tests++;
      if ({H, M, L} !== lvl || Ve !== mve || E !== me || Nivel !== 2'(mniv))
        begin n_fail++; $display("FAIL random cycle %0d got HML=%b Ve=%b E=%b Nivel=%0d want HML=%b Ve=%b E=%b Nivel=%0d", i, {H, M, L}, Ve, E, Nivel, lvl, mve, me, mniv); end
    end
    Reset = 1'b0; Limpa_Erro = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_glitch;
    test_erro;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
